// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch stage.
package mips_pkg;

    // Next-PC select codes; any other value behaves as sequential.
    localparam logic [2:0] PC_SRC_SEQ    = 3'd0;
    localparam logic [2:0] PC_SRC_BRANCH = 3'd1;
    localparam logic [2:0] PC_SRC_JUMP   = 3'd2;
    localparam logic [2:0] PC_SRC_REG    = 3'd3;

    // Default halt instruction encoding.
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    // Fetch controller states.
    typedef enum logic [1:0] {
        FETCH_RUN    = 2'd0,
        FETCH_LOAD   = 2'd1,
        FETCH_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_ram.sv
// Instruction memory: one write port, one registered read port, contents never reset.
module instr_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Synchronous read; rdata holds while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, IF/ID register, program load mode and halt detection.
module instr_fetch
    import mips_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       MEM_DEPTH = 2048,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEF)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2:0]                   in_pc_src,
    input  logic [ADDR_W-1:0]            in_branch_address,
    input  logic [ADDR_W-1:0]            in_pc_jump,
    input  logic [ADDR_W-1:0]            in_pc_register,
    input  logic                         stall_flag,
    input  logic                         in_flush,
    input  logic                         in_step_mode,
    input  logic                         in_step,
    input  logic                         debug_flag,
    input  logic                         wea_ram_inst,
    input  logic [DATA_W-1:0]            in_ins_to_mem,
    output logic [DATA_W-1:0]            out_instruction,
    output logic [ADDR_W-1:0]            out_pc,
    output logic                         out_valid,
    output logic                         out_halt_flag_if,
    output logic                         out_load_full,
    output logic [$clog2(MEM_DEPTH):0]   out_load_count
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4_c;
    logic [ADDR_W-1:0] pc_sel_c;
    logic [ADDR_W-1:0] ifid_pc_d;
    logic              valid_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              ram_we_c;
    logic              ram_re_c;
    logic [DATA_W-1:0] ram_q;
    logic              adv_c;
    logic              halt_hit_c;

    assign pc_plus4_c = pc_q + ADDR_W'(4);
    assign adv_c      = !stall_flag && (!in_step_mode || in_step);
    // The halt word is visible in IF/ID while still in RUN; freeze from that cycle on.
    assign halt_hit_c = (state_q == FETCH_RUN) && out_valid && (ram_q == HALT_WORD);

    // The RAM read register doubles as the IF/ID instruction; invalid slots read as zero.
    assign out_instruction  = out_valid ? ram_q : '0;
    assign out_halt_flag_if = (state_q == FETCH_HALTED) || halt_hit_c;
    // Count never exceeds MEM_DEPTH, so its top bit marks a full memory.
    assign out_load_full    = out_load_count[IDX_W];

    instr_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we_c),
        .waddr  (out_load_count[IDX_W-1:0]),
        .wdata  (in_ins_to_mem),
        .re     (ram_re_c),
        .raddr  (pc_q[2 +: IDX_W]),
        .rdata  (ram_q)
    );

    // Next-PC candidate selection.
    always_comb begin
        pc_sel_c = pc_plus4_c;
        case (in_pc_src)
            PC_SRC_BRANCH: pc_sel_c = in_branch_address;
            PC_SRC_JUMP:   pc_sel_c = in_pc_jump;
            PC_SRC_REG:    pc_sel_c = in_pc_register;
            default:       pc_sel_c = pc_plus4_c;
        endcase
    end

    // Fetch controller next state and datapath controls.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ifid_pc_d = out_pc;
        valid_d   = out_valid;
        cnt_d     = out_load_count;
        ram_we_c  = 1'b0;
        ram_re_c  = 1'b0;

        case (state_q)
            FETCH_LOAD: begin
                pc_d    = '0;
                valid_d = 1'b0;
                if (wea_ram_inst && !out_load_count[IDX_W]) begin
                    ram_we_c = 1'b1;
                    cnt_d    = out_load_count + CNT_W'(1);
                end
                if (!debug_flag) begin
                    state_d   = FETCH_RUN;
                    ifid_pc_d = '0;
                end
            end
            FETCH_RUN: begin
                if (halt_hit_c) begin
                    state_d = FETCH_HALTED;
                end else if (in_flush) begin
                    pc_d      = pc_sel_c;
                    ifid_pc_d = '0;
                    valid_d   = 1'b0;
                end else if (adv_c) begin
                    ram_re_c  = 1'b1;
                    pc_d      = pc_sel_c;
                    ifid_pc_d = pc_plus4_c;
                    valid_d   = 1'b1;
                end
            end
            FETCH_HALTED: begin
                state_d = FETCH_HALTED;
            end
            default: begin
                state_d = FETCH_RUN;
            end
        endcase

        // Load request from any other state restarts the loader.
        if (debug_flag && (state_q != FETCH_LOAD)) begin
            state_d  = FETCH_LOAD;
            pc_d     = '0;
            valid_d  = 1'b0;
            cnt_d    = '0;
            ram_re_c = 1'b0;
        end
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= FETCH_RUN;
            pc_q           <= '0;
            out_pc         <= '0;
            out_valid      <= 1'b0;
            out_load_count <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            out_pc         <= ifid_pc_d;
            out_valid      <= valid_d;
            out_load_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with a scoreboard of expected IF/ID contents.
module tb_instr_fetch;
    import mips_pkg::*;

    localparam int unsigned DEPTH = 2048;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        halt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  pc_src;
    logic [31:0] br_addr, jmp_addr, reg_addr;
    logic        stall, flush, step_mode, step, debug, wea;
    logic [31:0] wdata;

    logic [31:0] instr, pc_o;
    logic        valid, halt, full;
    logic [11:0] count;
    logic [31:0] instr16, pc16;
    logic        valid16, halt16, full16;
    logic [4:0]  count16;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    int          m_cnt;
    exp_t        last;
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .reset(reset), .in_pc_src(pc_src),
        .in_branch_address(br_addr), .in_pc_jump(jmp_addr), .in_pc_register(reg_addr),
        .stall_flag(stall), .in_flush(flush), .in_step_mode(step_mode), .in_step(step),
        .debug_flag(debug), .wea_ram_inst(wea), .in_ins_to_mem(wdata),
        .out_instruction(instr), .out_pc(pc_o), .out_valid(valid),
        .out_halt_flag_if(halt), .out_load_full(full), .out_load_count(count)
    );

    instr_fetch #(.MEM_DEPTH(16)) dut16 (
        .clk(clk), .reset(reset), .in_pc_src(pc_src),
        .in_branch_address(br_addr), .in_pc_jump(jmp_addr), .in_pc_register(reg_addr),
        .stall_flag(stall), .in_flush(flush), .in_step_mode(step_mode), .in_step(step),
        .debug_flag(debug), .wea_ram_inst(wea), .in_ins_to_mem(wdata),
        .out_instruction(instr16), .out_pc(pc16), .out_valid(valid16),
        .out_halt_flag_if(halt16), .out_load_full(full16), .out_load_count(count16)
    );

    function automatic logic [31:0] sel_pc(input logic [2:0] s, input logic [31:0] pc);
        case (s)
            3'd1:    return br_addr;
            3'd2:    return jmp_addr;
            3'd3:    return reg_addr;
            default: return pc + 32'd4;
        endcase
    endfunction

    function automatic int widx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'(DEPTH - 1));
    endfunction

    // Expected IF/ID contents after the coming edge, from the current inputs.
    task automatic model_cycle(output exp_t e);
        if (last.halt) begin
            e = last;
        end else if (flush) begin
            m_pc = sel_pc(pc_src, m_pc);
            e = '0;
        end else if (!stall && (!step_mode || step)) begin
            e       = '0;
            e.instr = m_mem[widx(m_pc)];
            e.pc    = m_pc + 32'd4;
            e.valid = 1'b1;
            e.halt  = (e.instr == HALT_WORD_DEF);
            m_pc    = sel_pc(pc_src, m_pc);
        end else begin
            e = last;
        end
        last = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_load();
        debug = 1'b1; wea = 1'b0;
        tick();
        m_cnt = 0;
    endtask

    task automatic load_word(input logic [31:0] w);
        debug = 1'b1; wea = 1'b1; wdata = w;
        tick();
        if (m_cnt < DEPTH) m_mem[m_cnt] = w;
        m_cnt++;
        wea = 1'b0;
    endtask

    task automatic leave_load();
        debug = 1'b0; wea = 1'b0;
        tick();
        m_pc = 32'h0;
        last = '0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
        checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_o); end
        checks++; if ({valid, halt, full} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {valid, halt, full}); end
        checks++; if (count !== 12'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if ({instr16, pc16, valid16, halt16, full16, count16} !== '0) begin
            errors++; $display("FAIL reset_dut16 got %h/%h/%b%b%b/%0d want all zero", instr16, pc16, valid16, halt16, full16, count16);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_program();
        exp_t e, got;
        enter_load();
        load_word(32'hAC03_0000);
        load_word(32'hAC03_3333);
        load_word(HALT_WORD_DEF);
        leave_load();
        checks++; if (count !== 12'd3) begin errors++; $display("FAIL prog_count got %0d want 3", count); end
        checks++; if ({instr, pc_o, valid} !== 65'h0) begin errors++; $display("FAIL prog_ifid_clear got %h/%h/%b want 0/0/0", instr, pc_o, valid); end
        pc_src = 3'd0; step_mode = 1'b0; step = 1'b0;
        for (int c = 0; c < 6; c++) begin
            stall = (c == 4);
            flush = (c == 5);
            model_cycle(e);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            checks++;
            if ({instr, pc_o, valid, halt} !== got) begin
                errors++;
                $display("FAIL prog cyc %0d got %h/%h/%b/%b want %h/%h/%b/%b", c, instr, pc_o, valid, halt, got.instr, got.pc, got.valid, got.halt);
            end
        end
        checks++;
        if (pc_o !== 32'hC || halt !== 1'b1 || instr !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL prog_halted got %h/%b/%h want 0000000c/1/ffffffff", pc_o, halt, instr);
        end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_pc_select();
        exp_t e, got;
        logic [2:0]  srcs [7] = '{3'd1, 3'd0, 3'd0, 3'd2, 3'd3, 3'd5, 3'd0};
        logic [31:0] brs  [7] = '{32'h40, 32'h104, 32'h104, 32'h104, 32'h104, 32'h104, 32'h104};
        logic [31:0] jmps [7] = '{32'h208, 32'h208, 32'h208, 32'h8, 32'h208, 32'h208, 32'h208};
        logic [31:0] regs [7] = '{32'h30C, 32'h30C, 32'h30C, 32'h30C, 32'h2003, 32'h30C, 32'h30C};
        logic        stl  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        fls  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        enter_load();
        for (int i = 0; i < 20; i++) load_word(32'h5000_0000 + 32'(i));
        leave_load();
        for (int r = 0; r < 7; r++) begin
            pc_src = srcs[r]; br_addr = brs[r]; jmp_addr = jmps[r]; reg_addr = regs[r];
            stall = stl[r]; flush = fls[r];
            model_cycle(e);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            checks++;
            if ({instr, pc_o, valid, halt} !== got) begin
                errors++;
                $display("FAIL pcsel row %0d got %h/%h/%b/%b want %h/%h/%b/%b", r, instr, pc_o, valid, halt, got.instr, got.pc, got.valid, got.halt);
            end
        end
        checks++;
        if (pc_o !== 32'h200B || instr !== 32'h5000_0001) begin
            errors++; $display("FAIL pcsel_wrap got %h/%h want 0000200b/50000001", pc_o, instr);
        end
        stall = 1'b0; flush = 1'b0; pc_src = 3'd0;
    endtask

    task automatic test_step();
        exp_t e, got;
        step_mode = 1'b1;
        for (int c = 0; c < 13; c++) begin
            step      = (c % 4 == 3);
            stall     = (c == 11);
            step_mode = (c != 12);
            model_cycle(e);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            checks++;
            if ({instr, pc_o, valid, halt} !== got) begin
                errors++;
                $display("FAIL step cyc %0d got %h/%h/%b/%b want %h/%h/%b/%b", c, instr, pc_o, valid, halt, got.instr, got.pc, got.valid, got.halt);
            end
        end
        step = 1'b0; stall = 1'b0; step_mode = 1'b0;
    endtask

    task automatic test_load_full();
        exp_t e, got;
        enter_load();
        for (int i = 0; i < 20; i++) load_word(32'h1000 + 32'(i));
        checks++; if (count16 !== 5'd16 || full16 !== 1'b1) begin errors++; $display("FAIL full16 got %0d/%b want 16/1", count16, full16); end
        checks++; if (count !== 12'd20 || full !== 1'b0) begin errors++; $display("FAIL full2048 got %0d/%b want 20/0", count, full); end
        leave_load();
        for (int c = 0; c < 2; c++) begin
            pc_src = (c == 0) ? 3'd2 : 3'd0;
            jmp_addr = 32'h40;
            model_cycle(e);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            checks++;
            if ({instr, pc_o, valid, halt} !== got) begin
                errors++;
                $display("FAIL wrapfetch cyc %0d got %h/%h/%b/%b want %h/%h/%b/%b", c, instr, pc_o, valid, halt, got.instr, got.pc, got.valid, got.halt);
            end
            checks++;
            if (instr16 !== 32'h1000 || pc16 !== ((c == 0) ? 32'h4 : 32'h44)) begin
                errors++; $display("FAIL wrap16 cyc %0d got %h/%h want 00001000/%h", c, instr16, pc16, (c == 0) ? 32'h4 : 32'h44);
            end
        end
        pc_src = 3'd0;
    endtask

    task automatic test_reset_mid();
        exp_t e, got;
        model_cycle(e);
        sb.push_back(e);
        tick();
        got = sb.pop_front();
        checks++;
        if ({instr, pc_o, valid, halt} !== got) begin
            errors++; $display("FAIL pre_reset got %h/%h/%b/%b want %h/%h/%b/%b", instr, pc_o, valid, halt, got.instr, got.pc, got.valid, got.halt);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({instr, pc_o, valid, halt, full, count} !== '0) begin
            errors++; $display("FAIL midreset got %h/%h/%b%b%b/%0d want all zero", instr, pc_o, valid, halt, full, count);
        end
        tick();
        checks++;
        if ({instr, pc_o, valid, instr16, pc16, valid16} !== '0) begin
            errors++; $display("FAIL midreset_hold got %h/%h/%b %h/%h/%b want all zero", instr, pc_o, valid, instr16, pc16, valid16);
        end
        #1 reset = 1'b1;
        m_pc = 32'h0;
        last = '0;
        for (int c = 0; c < 2; c++) begin
            model_cycle(e);
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            checks++;
            if ({instr, pc_o, valid, halt} !== got) begin
                errors++; $display("FAIL restart cyc %0d got %h/%h/%b/%b want %h/%h/%b/%b", c, instr, pc_o, valid, halt, got.instr, got.pc, got.valid, got.halt);
            end
        end
        checks++;
        if (instr16 !== 32'h1001 || pc16 !== 32'h8) begin
            errors++; $display("FAIL restart16 got %h/%h want 00001001/00000008", instr16, pc16);
        end
    endtask

    initial begin
        reset = 1'b0;
        pc_src = 3'd0; br_addr = '0; jmp_addr = '0; reg_addr = '0;
        stall = 1'b1; flush = 1'b0; step_mode = 1'b0; step = 1'b0;
        debug = 1'b0; wea = 1'b0; wdata = '0;
        m_pc = '0; m_cnt = 0; last = '0;
        test_reset();
        test_program();
        test_pc_select();
        test_step();
        test_load_full();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DATA_W, 32, instruction width in bits.
REQ-002 Parameter ADDR_W, 32, PC width in bits (byte address).
REQ-003 Parameter MEM_DEPTH, 2048, instruction memory depth in words, power of two.
REQ-004 Parameter HALT_WORD, 32'hFFFF_FFFF, encoding of the halt instruction.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_pc_src  input  3  next-PC select: 0 sequential, 1 branch, 2 jump, 3 register; 4-7 treated as 0.
REQ-008 in_branch_address, in_pc_jump, in_pc_register  input  ADDR_W each  next-PC candidates for codes 1/2/3.
REQ-009 stall_flag  input  1  hold PC and IF/ID register.
REQ-010 in_flush  input  1  squash the instruction being fetched (bubble into IF/ID).
REQ-011 in_step_mode, in_step  input  1 each  single-step enable; one-cycle advance pulse.
REQ-012 debug_flag, wea_ram_inst  input  1 each  load mode; write strobe.
REQ-013 in_ins_to_mem  input  DATA_W  word to load.
REQ-014 out_instruction  output  DATA_W  IF/ID instruction register.
REQ-015 out_pc  output  ADDR_W  IF/ID register: fetched PC + 4.
REQ-016 out_valid, out_halt_flag_if, out_load_full  output  1 each  IF/ID holds a real instruction; halt fetched; load memory full.
REQ-017 out_load_count  output  $clog2(MEM_DEPTH)+1  number of words loaded.

Function
REQ-018 FSM states RUN, LOAD, HALTED; debug_flag=1 in any state moves to LOAD next edge, clearing write pointer and out_load_count to 0.
REQ-019 LOAD: each edge with wea_ram_inst=1 writes in_ins_to_mem to mem[wr_ptr], wr_ptr and out_load_count increment; PC held at 0; out_valid=0.
REQ-020 LOAD: when out_load_count=MEM_DEPTH, out_load_full=1 and further writes are ignored (no wrap).
REQ-021 LOAD with debug_flag=0 moves to RUN; PC=0, IF/ID cleared (instruction 0, out_pc 0, out_valid 0).
REQ-022 RUN advance condition adv = !stall_flag and (!in_step_mode or in_step).
REQ-023 On adv: out_instruction <= mem[PC[2+:log2(MEM_DEPTH)]], out_pc <= PC+4, out_valid <= 1, PC <= selected next PC; latency PC-to-out_instruction one cycle.
REQ-024 Word index uses low log2(MEM_DEPTH) bits of PC>>2; out-of-range PCs wrap modulo depth; PC[1:0] ignored.
REQ-025 Sequential next PC = PC+4, modulo 2^ADDR_W.
REQ-026 No adv, no flush: PC, out_instruction, out_pc, out_valid hold.
REQ-027 in_flush=1 in RUN dominates stall_flag and step: PC loads selected next PC, out_instruction <= 0, out_valid <= 0, out_pc <= 0.
REQ-028 When a word equal to HALT_WORD is latched with out_valid=1, out_halt_flag_if=1 that same cycle and state moves to HALTED.
REQ-029 HALTED: PC and IF/ID frozen, out_halt_flag_if stays 1, stall/flush/step ignored; exit only via reset or debug_flag.
REQ-030 Memory contents are not reset and persist across reset.

Reset
REQ-031 Reset asserted: state RUN, PC 0, wr_ptr 0, out_instruction 0, out_pc 0, out_valid 0, out_halt_flag_if 0, out_load_full 0, out_load_count 0, immediately and asynchronously.

Structure
REQ-032 Shared package mips_pkg holds PC_SRC codes, HALT_WORD default, fetch FSM state encoding.
REQ-033 One sub-module instr_ram: simple dual-port, one write port, one synchronous-read port with read enable, depth MEM_DEPTH, no reset.

Verification
REQ-034 Load 32'hAC030000, 32'hAC033333, HALT_WORD, drop debug_flag -> out_load_count 3; out_instruction AC030000/out_pc 4, then AC033333/8, then halt flag 1 with PC frozen at 12.
REQ-035 RUN, in_pc_src=1, in_branch_address=32'h40, in_flush=1 together with stall_flag=1 -> next cycle out_valid 0, instruction 0; following cycle out_pc 32'h44, mem[16] fetched.
REQ-036 in_step_mode=1, in_step pulsed every 4th cycle -> PC advances by 4 exactly once per pulse; stall_flag=1 coinciding with a pulse -> no advance.
REQ-037 MEM_DEPTH=16 loaded with 20 writes -> out_load_count 16, out_load_full 1, mem[0] unchanged; PC 32'h40 fetches mem[0].
REQ-038 Reset asserted mid-RUN between edges -> all outputs zero immediately; after release fetch restarts at PC 0 with previously loaded contents.
